// File: rtl/fault_syndrome_collector.sv
// Per-fault syndrome collector: compares golden/faulty outputs per pattern and emits one
// dictionary entry per fault. Optional build macro FAULT_DROP_EN ends collection at first mismatch.
module fault_syndrome_collector #(
  parameter int unsigned OUT_W      = 123,
  parameter int unsigned TEST_COUNT = 124,
  parameter int unsigned FID_W      = 13,
  parameter int unsigned CNT_W      = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FID_W-1:0]      fault_id,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic [OUT_W-1:0]      golden,
  input  logic [OUT_W-1:0]      faulty,
  input  logic                  pat_last,
  output logic                  entry_valid,
  input  logic                  entry_ready,
  output logic [FID_W-1:0]      entry_fault_id,
  output logic [TEST_COUNT-1:0] entry_syndrome,
  output logic                  entry_detected,
  output logic [CNT_W-1:0]      fault_count,
  output logic [CNT_W-1:0]      det_count,
  output logic                  busy,
  output logic                  err_overflow
);

  localparam int unsigned IDX_W = (TEST_COUNT > 1) ? $clog2(TEST_COUNT) : 1;
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(TEST_COUNT - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

  state_e                  state_q, state_d;
  logic [FID_W-1:0]        fid_q, fid_d;
  logic [TEST_COUNT-1:0]   syn_q, syn_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        fc_q, fc_d;
  logic [CNT_W-1:0]        dc_q, dc_d;
  logic                    ovf_q, ovf_d;
  logic                    mismatch;
  logic                    drop_hit;

  assign mismatch = |(golden ^ faulty);

`ifdef FAULT_DROP_EN
  assign drop_hit = mismatch;
`else
  assign drop_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fid_d   = fid_q;
    syn_d   = syn_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    dc_d    = dc_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          fid_d   = fault_id;
          syn_d   = '0;
          idx_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (pat_valid) begin
          syn_d[idx_q] = mismatch;
          idx_d        = idx_q + 1'b1;
          if (pat_last || (idx_q == IdxLast) || drop_hit) state_d = StEmit;
          // A dropped fault ends early on purpose, so it never counts as an overflow.
          if ((idx_q == IdxLast) && !pat_last && !drop_hit) ovf_d = 1'b1;
        end
      end
      StEmit: begin
        if (entry_ready) begin
          state_d = StIdle;
          if (fc_q != CntMax) fc_d = fc_q + 1'b1;
          if ((|syn_q) && (dc_q != CntMax)) dc_d = dc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fid_q   <= '0;
      syn_q   <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      dc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fid_q   <= fid_d;
      syn_q   <= syn_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      dc_q    <= dc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pat_ready      = (state_q == StCollect);
  assign entry_valid    = (state_q == StEmit);
  assign busy           = (state_q != StIdle);
  assign entry_fault_id = fid_q;
  assign entry_syndrome = syn_q;
  assign entry_detected = |syn_q;
  assign fault_count    = fc_q;
  assign det_count      = dc_q;
  assign err_overflow   = ovf_q;

endmodule
